// File: rtl/dispatch_port_arbiter.sv
// Arbitrates the shared ROB-allocation / PRF-query port among the ALU, branch and LSU dispatch buffers.
// Round-robin grant with per-requester starvation escalation; grants are combinational, state is registered.
module dispatch_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mispredict,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dest_space,
  input  logic               rob_full,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               starve_mode,
  output logic [IDX_W-1:0]   rr_ptr
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STARVE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0] elig;
  logic               starve_hit;
  logic [IDX_W-1:0]   starve_idx;
  logic               rr_hit;
  logic [IDX_W-1:0]   rr_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_at_limit;

  assign elig = req & dest_space & {NUM_REQ{~(rob_full | mispredict | reset)}};

  // Round-robin scan is split into two passes (rr_ptr..top, then 0..rr_ptr-1) to avoid a modulo.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    rr_hit     = 1'b0;
    rr_idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!starve_hit && elig[i] && (wait_cnt_q[i] == LIMIT_C)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_hit && elig[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_hit && elig[i]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(i);
      end
    end
    if ((state_q == ST_STARVE) && starve_hit) begin
      pick_valid = 1'b1;
      pick_idx   = starve_idx;
    end else begin
      pick_valid = rr_hit;
      pick_idx   = rr_idx;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = pick_valid && (pick_idx == IDX_W'(i));
    end
    gnt_valid = pick_valid;
    gnt_idx   = pick_valid ? pick_idx : '0;
  end

  // Backpressured requesters hold their age; only eligible losers count toward starvation.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    any_at_limit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req[i] || gnt[i]) begin
        wait_cnt_d[i] = '0;
      end else if (elig[i] && (wait_cnt_q[i] != LIMIT_C)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
      end
    end
    if (mispredict) begin
      wait_cnt_d = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wait_cnt_d[i] == LIMIT_C) begin
        any_at_limit = 1'b1;
      end
    end
    state_d = (any_at_limit && !mispredict) ? ST_STARVE : ST_NORMAL;
    if (pick_valid) begin
      rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign starve_mode = (state_q == ST_STARVE);
  assign rr_ptr      = rr_ptr_q;

endmodule

// File: tb/tb_dispatch_port_arbiter.sv
// Scoreboard bench for dispatch_port_arbiter: a behavioural model queues expected outputs per cycle,
// and each scenario task also checks the hand-derived values for its scenario.
module tb_dispatch_port_arbiter;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        gv;
    logic [1:0]  idx;
    logic        sm;
    logic [1:0]  rr;
    logic [11:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mispredict = 1'b0;
  logic       rob_full = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] dest_space = 3'b000;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       starve_mode;
  logic [1:0] rr_ptr;

  vec_t exp_q[$];
  vec_t obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   m_rr = 0;
  int   m_cnt[3] = '{0, 0, 0};
  logic m_starve = 1'b0;

  dispatch_port_arbiter #(
    .NUM_REQ(3),
    .STARVE_LIMIT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mispredict(mispredict),
    .req(req),
    .dest_space(dest_space),
    .rob_full(rob_full),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx),
    .starve_mode(starve_mode),
    .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, queues the model's prediction and the sampled DUT outputs, then advances the model.
  task automatic step(input logic [2:0] r, input logic [2:0] sp, input logic rf,
                      input logic mp, input logic rst, output vec_t o);
    vec_t       e;
    int         win;
    int         j;
    logic [2:0] el;
    @(negedge clk);
    req        = r;
    dest_space = sp;
    rob_full   = rf;
    mispredict = mp;
    reset      = rst;
    #1;
    el  = r & sp & {3{~(rf | mp | rst)}};
    win = -1;
    if (m_starve) begin
      for (int i = 0; i < 3; i++) begin
        if (win < 0 && el[i] && m_cnt[i] == 8) win = i;
      end
    end
    for (int k = 0; k < 3; k++) begin
      j = (m_rr + k) % 3;
      if (win < 0 && el[j[1:0]]) win = j;
    end
    e.gnt = (win >= 0) ? 3'(1 << win) : 3'b000;
    e.gv  = (win >= 0);
    e.idx = (win >= 0) ? 2'(win) : 2'd0;
    e.sm  = m_starve;
    e.rr  = 2'(m_rr);
    e.cnt = {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
    exp_q.push_back(e);
    o.gnt = gnt;
    o.gv  = gnt_valid;
    o.idx = gnt_idx;
    o.sm  = starve_mode;
    o.rr  = rr_ptr;
    o.cnt = dut.wait_cnt_q;
    obs_q.push_back(o);
    if (rst) begin
      m_rr = 0;
      m_starve = 1'b0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (mp) begin
      m_starve = 1'b0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      m_starve = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (i == win || !r[i]) m_cnt[i] = 0;
        else if (el[i] && m_cnt[i] < 8) m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == 8) m_starve = 1'b1;
      end
      if (win >= 0) m_rr = (win + 1) % 3;
    end
  endtask

  task automatic test_reset();
    vec_t o, e;
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b1, o);
    vectors++;
    if (o.gnt !== 3'b000 || o.gv !== 1'b0 || o.idx !== 2'd0 || o.sm !== 1'b0 || o.rr !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got gnt=%b gv=%b idx=%0d sm=%b rr=%0d, need all zero", o.gnt, o.gv, o.idx, o.sm, o.rr);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL reset_sb got=%b need=%b", o, e); end
    end
  endtask

  task automatic test_round_robin();
    vec_t o, e;
    logic [2:0] exp_g[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] exp_r[6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
      vectors++;
      if (o.gnt !== exp_g[i] || o.rr !== exp_r[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_cycle%0d got gnt=%b rr=%0d, need gnt=%b rr=%0d", i, o.gnt, o.rr, exp_g[i], exp_r[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL rr_sb got=%b need=%b", o, e); end
    end
  endtask

  task automatic test_skip_idle();
    vec_t o, e;
    for (int i = 0; i < 4; i++) begin
      step(3'b101, 3'b111, 1'b0, 1'b0, 1'b0, o);
      vectors++;
      if (o.gnt !== ((i % 2 == 0) ? 3'b001 : 3'b100)) begin
        miscompares++;
        $display("[TB] FAIL skip_gnt%0d got=%b need=%b", i, o.gnt, (i % 2 == 0) ? 3'b001 : 3'b100);
      end
      if (i > 0) begin
        vectors++;
        if (o.cnt[7:4] !== 4'd0) begin
          miscompares++;
          $display("[TB] FAIL skip_branch_cnt%0d got=%0d need=0", i, o.cnt[7:4]);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL skip_sb got=%b need=%b", o, e); end
    end
  endtask

  task automatic test_rs_full();
    vec_t o, e;
    logic seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 3'b011, 1'b0, 1'b0, 1'b0, o);
      vectors++;
      if (o.gnt[2] !== 1'b0 || o.cnt[11:8] !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL rsfull_lsu%0d got gnt=%b cnt=%0d need lsu ungranted cnt=0", i, o.gnt, o.cnt[11:8]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
      if (o.gnt[2] === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsfull_resume got lsu_granted=%b need=1", seen);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL rsfull_sb got=%b need=%b", o, e); end
    end
  endtask

  // Branch loses eight times: all-eligible cycles at rr_ptr=0, with its RS blocked whenever rr_ptr=1.
  task automatic lose_branch_eight();
    vec_t o;
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b1, o);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) step(3'b111, 3'b101, 1'b0, 1'b0, 1'b0, o);
      step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    end
  endtask

  task automatic test_starvation();
    vec_t o, e;
    lose_branch_eight();
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.sm !== 1'b1 || o.gnt !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL starve_enter got sm=%b gnt=%b need sm=1 gnt=010", o.sm, o.gnt);
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.cnt[7:4] !== 4'd0 || o.sm !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL starve_clear got cnt1=%0d sm=%b need 0 0", o.cnt[7:4], o.sm);
    end
    lose_branch_eight();
    step(3'b111, 3'b101, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.sm !== 1'b1 || o.gnt !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL starve_fallback got sm=%b gnt=%b need sm=1 gnt=100", o.sm, o.gnt);
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.rr !== 2'd0 || o.gnt !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL starve_override got rr=%0d gnt=%b need rr=0 gnt=010", o.rr, o.gnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL starve_sb got=%b need=%b", o, e); end
    end
  endtask

  task automatic test_rob_full();
    vec_t o, e;
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b1, o);
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b111, 1'b1, 1'b0, 1'b0, o);
      vectors++;
      if (o.gnt !== 3'b000 || o.gv !== 1'b0 || o.rr !== 2'd2 || o.cnt !== 12'h201) begin
        miscompares++;
        $display("[TB] FAIL robfull%0d got gnt=%b gv=%b rr=%0d cnt=%h need 000 0 2 201", i, o.gnt, o.gv, o.rr, o.cnt);
      end
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.gnt !== 3'b100 || o.idx !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL robfull_resume got gnt=%b idx=%0d need 100 2", o.gnt, o.idx);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL robfull_sb got=%b need=%b", o, e); end
    end
  endtask

  task automatic test_flush_and_reset();
    vec_t o, e;
    step(3'b111, 3'b111, 1'b0, 1'b1, 1'b0, o);
    vectors++;
    if (o.gnt !== 3'b000 || o.cnt !== 12'h012) begin
      miscompares++;
      $display("[TB] FAIL flush_cycle got gnt=%b cnt=%h need 000 012", o.gnt, o.cnt);
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.cnt !== 12'h000 || o.sm !== 1'b0 || o.rr !== 2'd0 || o.gnt !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL flush_after got cnt=%h sm=%b rr=%0d gnt=%b need 000 0 0 001", o.cnt, o.sm, o.rr, o.gnt);
    end
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, o);
    step(3'b111, 3'b111, 1'b0, 1'b0, 1'b1, o);
    vectors++;
    if (o.gnt !== 3'b000 || o.gv !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_cycle got gnt=%b gv=%b need 000 0", o.gnt, o.gv);
    end
    step(3'b110, 3'b111, 1'b0, 1'b0, 1'b0, o);
    vectors++;
    if (o.rr !== 2'd0 || o.gnt !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL midreset_after got rr=%0d gnt=%b need 0 010", o.rr, o.gnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL flush_sb got=%b need=%b", o, e); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_rs_full();
    test_starvation();
    test_rob_full();
    test_flush_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
